demux_scan_sequencer: RTL and testbench
=======================================

Name: demux_scan_sequencer

Overview:
- Upstream driver for the 1-to-8 demultiplexer. Generates the `sel`, `addr[2:0]` and data bit that the demux consumes.
- Sweeps round-robin over a programmable set of enabled channels.
- Holds each channel for a programmable dwell time, then moves on.
- Runs one sweep or continuous sweeps. Reports sweep completion and keeps a sweep count.

Parameters:
- DWELL_W, 4, width of the dwell input; each channel is held for `dwell+1` cycles (1..2^DWELL_W).

Ports:
- `clk` input 1 system clock, rising edge.
- `rst` input 1 reset. Asynchronous, active-high.
- `start` input 1 one-cycle pulse; begins a scan when idle.
- `stop` input 1 aborts the scan; sequencer returns to IDLE.
- `mode` input 1 0 = single sweep, 1 = continuous.
- `en_mask` input 8 channel enable mask; bit i enables channel i.
- `dwell` input DWELL_W hold cycles per channel, minus 1.
- `data_in` input 1 serial data to be routed.
- `sel` output 1 demux enable (registered).
- `addr` output 3 demux channel select (registered).
- `dout` output 1 data bit for the demux `in` (registered).
- `busy` output 1 high while in SCAN.
- `sweep_done` output 1 one-cycle pulse per completed sweep.
- `sweep_cnt` output 8 completed sweeps since last start; wraps 255->0.

Behaviour:

Reset (async assert, sync release):
- `sel`=0, `addr`=0, `dout`=0, `busy`=0, `sweep_done`=0, `sweep_cnt`=0.
- State = IDLE; internal `mask_q`, `dwell_q` and dwell counter = 0.
- Reset asserted mid-scan clears everything immediately; no done pulse.

States: IDLE and SCAN.

IDLE -> SCAN:
- Transition occurs when `start`=1 and `en_mask`!=0.
- At that edge: `mask_q`<=`en_mask`, `dwell_q`<=`dwell`, `sweep_cnt`<=0.
- Also at that edge: `addr`<= lowest set bit of `en_mask`, `sel`<=1, dwell counter<=0.
- `start` with `en_mask`=0 is ignored; the block stays in IDLE.

SCAN:
- `mask_q` and `dwell_q` are frozen for the whole scan; changes to `en_mask`/`dwell` take effect only at the next start.
- `start` is ignored while in SCAN.
- The dwell counter increments each cycle. When it equals `dwell_q`, the current cycle is the channel's last.
- At the next edge `addr`<= next enabled index above the current one, with wrap 7->0 searching upward. The counter resets to 0.
- Output is gap-free: `sel` stays 1 across channel changes.
- Sweep boundary: the next enabled index is <= the current index (wrap). With a single enabled channel, every channel end is a boundary.

At a sweep boundary:
- `mode`=0: go to IDLE. `sel`<=0, `addr` holds its last value, `sweep_done`<=1 for one cycle (coincident with the first `sel`=0 cycle), `sweep_cnt`+=1.
- `mode`=1: stay in SCAN with `addr`<= first enabled channel. `sweep_done` pulses in the same cycle as that first channel's first cycle. `sweep_cnt`+=1.
- `mode` is sampled live at each boundary.

`stop`=1 in SCAN:
- Next edge: IDLE, `sel`<=0, counter cleared.
- No `sweep_done`, no count increment.
- `stop` takes priority over a simultaneous boundary.
- `stop` in IDLE has no effect.

`dout`:
- `dout`<=`data_in` when the next state is SCAN, else 0.
- One-cycle latency, aligned with `sel`/`addr` of the same cycle.

`busy`:
- `busy` = (state == SCAN), registered, equal to `sel`.

Every enabled channel gets exactly `dwell+1` cycles per sweep, in ascending order.

Test Plan:
1. Reset, `en_mask`=8'hFF, `dwell`=0, `mode`=0, start -> `addr` 0..7 on 8 consecutive cycles with `sel`=1. Next cycle `sel`=0, `sweep_done`=1, `sweep_cnt`=1, `busy`=0.
2. `en_mask`=8'b1010_0100, `dwell`=2, `mode`=0 -> `addr`=2,2,2,5,5,5,7,7,7, then `sel`=0 with done pulse. `dout` tracks `data_in` with 1-cycle delay.
3. `en_mask`=8'h81, `dwell`=1, `mode`=1, run 3 sweeps -> `addr` sequence 0,0,7,7,0,0,7,7…; `sweep_done` pulses on the cycles where `addr` returns to 0 after 7; `sweep_cnt` reaches 3. Then `stop` -> `sel`=0 next cycle, `sweep_cnt` stays 3, no extra pulse.
4. Start with `en_mask`=0 -> remains IDLE, `sel`=0. Start with `en_mask`=8'h10 and change `en_mask` to 8'hFF mid-scan -> only `addr`=4 driven.
5. `en_mask`=8'h01, `mode`=1, `dwell`=0 -> `sweep_done` high every cycle and `sweep_cnt` increments each cycle. Run 256 cycles -> `sweep_cnt` wraps to 0.
6. Assert `rst` mid-dwell on channel 3 -> `sel`/`addr`/`dout`/`busy`/`sweep_cnt` go 0 asynchronously before the next edge. `start` and `stop` asserted together in IDLE -> scan starts.

Source files
------------

// File: rtl/demux_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_scan_sequencer                                         |
// | Description : Round-robin channel scanner driving sel/addr/dout of a 1:8   |
// |               demux with programmable per-channel dwell and sweep count.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module demux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_in,
    output logic               sel,
    output logic [2:0]         addr,
    output logic               dout,
    output logic               busy,
    output logic               sweep_done,
    output logic [7:0]         sweep_cnt
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

    logic [0:0]         r_state;
    logic [7:0]         r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dcnt;
    logic               r_sel;
    logic [2:0]         r_addr;
    logic               r_dout;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_sweep_cnt;

    logic [2:0]         w_first;
    logic [2:0]         w_next;
    logic [2:0]         w_idx;
    logic               w_found;
    logic               w_last;
    logic               w_wrap;

    // Lowest enabled channel of the live mask, used only at scan start.
    always_comb begin
        w_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en_mask[i]) begin
                w_first = 3'(i);
            end
        end
    end

    // Next enabled channel strictly above the current one, searching upward
    // with wrap; falls back to the current channel when it is the only one.
    always_comb begin
        w_next  = r_addr;
        w_found = 1'b0;
        w_idx   = r_addr;
        for (int i = 1; i < 8; i++) begin
            w_idx = r_addr + 3'(i);
            if (!w_found && r_mask[w_idx]) begin
                w_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_last = (r_dcnt == r_dwell);
    assign w_wrap = (w_next <= r_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_mask      <= 8'd0;
            r_dwell     <= '0;
            r_dcnt      <= '0;
            r_sel       <= 1'b0;
            r_addr      <= 3'd0;
            r_dout      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sweep_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start && (en_mask != 8'd0)) begin
                        r_state     <= c_ST_SCAN;
                        r_mask      <= en_mask;
                        r_dwell     <= dwell;
                        r_dcnt      <= '0;
                        r_sweep_cnt <= 8'd0;
                        r_addr      <= w_first;
                        r_sel       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_dout      <= data_in;
                    end else begin
                        r_sel  <= 1'b0;
                        r_busy <= 1'b0;
                        r_dout <= 1'b0;
                    end
                end
                c_ST_SCAN: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                        r_dcnt  <= '0;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_dout  <= 1'b0;
                    end else if (w_last) begin
                        r_dcnt <= '0;
                        if (w_wrap) begin
                            r_sweep_cnt <= r_sweep_cnt + 8'd1;
                            r_done      <= 1'b1;
                        end
                        // Single sweep ends here; addr keeps the last channel.
                        if (w_wrap && !mode) begin
                            r_state <= c_ST_IDLE;
                            r_sel   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_dout  <= 1'b0;
                        end else begin
                            r_addr <= w_next;
                            r_dout <= data_in;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                        r_dout <= data_in;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign addr       = r_addr;
    assign dout       = r_dout;
    assign busy       = r_busy;
    assign sweep_done = r_done;
    assign sweep_cnt  = r_sweep_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_demux_scan_sequencer                                      |
// | Description : Vector table plus random stimulus against a schedule model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_demux_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] en_mask;
    logic [3:0] dwell;
    logic       data_in;
    logic       sel;
    logic [2:0] addr;
    logic       dout;
    logic       busy;
    logic       sweep_done;
    logic [7:0] sweep_cnt;

    int n_total;
    int n_pass;

    demux_scan_sequencer #(.DWELL_W(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .en_mask    (en_mask),
        .dwell      (dwell),
        .data_in    (data_in),
        .sel        (sel),
        .addr       (addr),
        .dout       (dout),
        .busy       (busy),
        .sweep_done (sweep_done),
        .sweep_cnt  (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a sweep is a flat per-cycle list of channel numbers.
    bit       m_busy;
    bit [2:0] m_addr;
    bit       m_dout;
    bit       m_done;
    bit [7:0] m_cnt;
    int       m_list[$];
    int       m_pos;

    typedef struct {
        bit       start;
        bit [7:0] mask;
        bit [3:0] dwell;
        bit       din;
        bit       exp_sel;
        bit [2:0] exp_addr;
        bit       exp_done;
        bit [7:0] exp_cnt;
        bit       exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_addr = 0; m_dout = 0; m_done = 0; m_cnt = 0;
        m_list.delete(); m_pos = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (!m_busy) begin
            m_dout = 0;
            if (start && en_mask != 0) begin
                m_list.delete();
                for (int ch = 0; ch < 8; ch++)
                    if (en_mask[ch])
                        for (int k = 0; k <= int'(dwell); k++) m_list.push_back(ch);
                m_pos = 0; m_busy = 1; m_cnt = 0;
                m_addr = 3'(m_list[0]); m_dout = data_in;
            end
        end else if (stop) begin
            m_busy = 0; m_dout = 0;
        end else begin
            m_pos++;
            if (m_pos == m_list.size()) begin
                m_cnt++; m_done = 1;
                if (mode) begin
                    m_pos = 0; m_addr = 3'(m_list[0]); m_dout = data_in;
                end else begin
                    m_busy = 0; m_dout = 0;
                end
            end else begin
                m_addr = 3'(m_list[m_pos]); m_dout = data_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("sel", sel, m_busy);
        chk("busy", busy, m_busy);
        chk("addr", addr, m_addr);
        chk("dout", dout, m_dout);
        chk("sweep_done", sweep_done, m_done);
        chk("sweep_cnt", sweep_cnt, m_cnt);
    endtask

    function automatic vec_t mk(bit s, bit [7:0] mk_mask, bit [3:0] dw, bit din,
                                bit es, bit [2:0] ea, bit ed, bit [7:0] ec, bit eo);
        vec_t v;
        v.start = s; v.mask = mk_mask; v.dwell = dw; v.din = din;
        v.exp_sel = es; v.exp_addr = ea; v.exp_done = ed; v.exp_cnt = ec; v.exp_dout = eo;
        return v;
    endfunction

    initial begin
        int seq2[8];
        n_total = 0; n_pass = 0;

        // Full-mask single sweep, dwell 0.
        vecs.push_back(mk(1, 8'hFF, 0, 1, 1, 0, 0, 0, 1));
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(0, 8'hFF, 0, ~i[0], 1, 3'(i), 0, 0, ~i[0]));
        vecs.push_back(mk(0, 8'hFF, 0, 1, 0, 7, 1, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 0, 1, 0, 7, 0, 1, 0));
        // Sparse mask 1010_0100, dwell 2.
        vecs.push_back(mk(1, 8'hA4, 2, 0, 1, 2, 0, 0, 0));
        seq2 = '{2, 2, 5, 5, 5, 7, 7, 7};
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 8'hA4, 2, i[0], 1, 3'(seq2[i]), 0, 0, i[0]));
        vecs.push_back(mk(0, 8'hA4, 2, 1, 0, 7, 1, 1, 0));

        rst = 1; start = 0; stop = 0; mode = 0; en_mask = 0; dwell = 0; data_in = 0;
        model_reset();
        #12;
        chk("reset_sel", sel, 0);
        chk("reset_addr", addr, 0);
        chk("reset_cnt", sweep_cnt, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            start = vecs[i].start; en_mask = vecs[i].mask;
            dwell = vecs[i].dwell; data_in = vecs[i].din; mode = 0;
            tick();
            chk($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_done", i), sweep_done, vecs[i].exp_done);
            chk($sformatf("vec%0d_cnt", i), sweep_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
        end
        start = 0;
        tick();

        // Continuous 0/7 sweeps, then stop.
        en_mask = 8'h81; dwell = 1; mode = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 12; i++) begin
            data_in = 1'($urandom);
            tick();
        end
        chk("cont_addr", addr, 0);
        chk("cont_done", sweep_done, 1);
        chk("cont_cnt", sweep_cnt, 3);
        stop = 1;
        tick();
        stop = 0;
        chk("stop_sel", sel, 0);
        chk("stop_cnt", sweep_cnt, 3);
        chk("stop_done", sweep_done, 0);
        tick();

        // Empty mask ignored; mask frozen during scan.
        en_mask = 0; start = 1; mode = 0;
        tick();
        chk("empty_sel", sel, 0);
        en_mask = 8'h10; dwell = 3;
        tick();
        start = 0; en_mask = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frozen_addr", addr, 4);
        end
        chk("frozen_end", sel, 0);

        // Single channel, dwell 0: done every cycle, count wraps.
        en_mask = 8'h01; dwell = 0; mode = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 256; i++) tick();
        chk("wrap_cnt", sweep_cnt, 0);
        chk("wrap_done", sweep_done, 1);
        stop = 1;
        tick();
        stop = 0;

        // Asynchronous reset mid-dwell on channel 3.
        en_mask = 8'h08; dwell = 7; start = 1; data_in = 1;
        tick();
        start = 0;
        tick(); tick();
        chk("pre_rst_addr", addr, 3);
        #2 rst = 1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_addr", addr, 0);
        chk("arst_dout", dout, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", sweep_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // start and stop together in IDLE still starts.
        en_mask = 8'h0F; dwell = 0; mode = 0; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("startstop_busy", busy, 1);
        for (int i = 0; i < 5; i++) tick();

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            en_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            dwell   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            data_in = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
